memory_access: RTL and testbench

Memory stage of the five-stage pipeline, directly downstream of the execute stage. Consumes the execute result, computed memory address, store data and load/store decode; drives a single-outstanding request/response data-memory bus. Produces the write-back value (`memory_o_valM`) with a retire pulse, and stalls the upstream pipeline while an access is in flight.

---
 rtl/memory_access_if.sv | 26 ++
 rtl/memory_access.sv | 189 ++++++++++++++++++
 tb/tb_memory_access.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// Data-memory bus between the memory stage and data memory.
// Single-outstanding req/ready, rvalid/rdata.
interface memory_access_if #(
  parameter int WIDTH = 32
);
  logic             mem_o_req;
  logic             mem_o_we;
  logic [WIDTH-1:0] mem_o_addr;
  logic [WIDTH-1:0] mem_o_wdata;
  logic [3:0]       mem_o_wstrb;
  logic             mem_i_ready;
  logic             mem_i_rvalid;
  logic [WIDTH-1:0] mem_i_rdata;

  modport master (
    output mem_o_req, mem_o_we, mem_o_addr,
    output mem_o_wdata, mem_o_wstrb,
    input  mem_i_ready, mem_i_rvalid, mem_i_rdata
  );

  modport slave (
    input  mem_o_req, mem_o_we, mem_o_addr,
    input  mem_o_wdata, mem_o_wstrb,
    output mem_i_ready, mem_i_rvalid, mem_i_rdata
  );
endinterface

// File: rtl/memory_access.sv
// Memory stage: issues loads/stores on the data bus,
// produces valM + retire pulse, stalls upstream in flight.
module memory_access #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regM_i_valid,
  input  logic [7:0]       regM_load_store_info_i,
  input  logic [WIDTH-1:0] regM_i_mem_addr,
  input  logic [WIDTH-1:0] regM_i_valB,
  input  logic [WIDTH-1:0] regM_i_valE,
  memory_access_if.master  bus,
  output logic [WIDTH-1:0] memory_o_valM,
  output logic             memory_o_valid,
  output logic             memory_o_misaligned,
  output logic             memory_o_stall
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       op;
  logic [1:0]       off;
  logic             illegal;
  logic             misal;
  logic             start;
  logic             fault;
  logic [7:0]       op_s;
  logic [WIDTH-1:0] st_wdata;
  logic [3:0]       st_wstrb;

  logic             req_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       wstrb_q;
  logic [4:0]       ld_op_q;
  logic [1:0]       off_q;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] ld_val;

  assign op  = regM_load_store_info_i;
  assign off = regM_i_mem_addr[1:0];

  // more than one op bit set
  assign illegal = (op & (op - 8'd1)) != 8'd0;
  assign misal =
    ((op[1] | op[4] | op[6]) & off[0]) |
    ((op[2] | op[7]) & (off != 2'b00));
  assign start = regM_i_valid & (op != 8'd0)
               & ~illegal & ~misal;
  assign fault = regM_i_valid & (op != 8'd0)
               & (illegal | misal);

  // keep the one-hot decoders free of multi-hot inputs
  assign op_s = illegal ? 8'd0 : op;

  always_comb begin
    st_wdata = '0;
    st_wstrb = 4'b0000;
    unique case (1'b1)
      op_s[5]: begin
        st_wdata = {(WIDTH/8){regM_i_valB[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      op_s[6]: begin
        st_wdata = {(WIDTH/16){regM_i_valB[15:0]}};
        st_wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      op_s[7]: begin
        st_wdata = regM_i_valB;
        st_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  assign shifted = bus.mem_i_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_val = '0;
    unique case (1'b1)
      ld_op_q[0]:
        ld_val = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      ld_op_q[1]:
        ld_val = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      ld_op_q[2]:
        ld_val = shifted;
      ld_op_q[3]:
        ld_val = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      ld_op_q[4]:
        ld_val = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    memory_o_stall = 1'b0;
    unique case (state)
      IDLE: begin
        memory_o_stall = start;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        memory_o_stall = ~(bus.mem_i_ready & we_q);
        if (bus.mem_i_ready)
          state_nxt = we_q ? IDLE : RESP;
      end
      RESP: begin
        memory_o_stall = ~bus.mem_i_rvalid;
        if (bus.mem_i_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q               <= 1'b0;
      we_q                <= 1'b0;
      addr_q              <= '0;
      wdata_q             <= '0;
      wstrb_q             <= 4'b0000;
      ld_op_q             <= 5'd0;
      off_q               <= 2'b00;
      memory_o_valM       <= '0;
      memory_o_valid      <= 1'b0;
      memory_o_misaligned <= 1'b0;
    end else begin
      memory_o_valid      <= 1'b0;
      memory_o_misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            req_q   <= 1'b1;
            we_q    <= |op[7:5];
            addr_q  <= {regM_i_mem_addr[WIDTH-1:2], 2'b00};
            wdata_q <= st_wdata;
            wstrb_q <= st_wstrb;
            ld_op_q <= op[4:0];
            off_q   <= off;
          end else if (regM_i_valid && op == 8'd0) begin
            memory_o_valM  <= regM_i_valE;
            memory_o_valid <= 1'b1;
          end else if (fault) begin
            memory_o_valM       <= '0;
            memory_o_valid      <= 1'b1;
            memory_o_misaligned <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_i_ready) begin
            req_q <= 1'b0;
            if (we_q) begin
              memory_o_valM  <= '0;
              memory_o_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          if (bus.mem_i_rvalid) begin
            memory_o_valM  <= ld_val;
            memory_o_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_o_req   = req_q;
  assign bus.mem_o_we    = we_q;
  assign bus.mem_o_addr  = addr_q;
  assign bus.mem_o_wdata = wdata_q;
  assign bus.mem_o_wstrb = wstrb_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: vector table plus
// hand sequences for wait states, reset and back-to-back.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regM_i_valid;
  logic [7:0]  regM_load_store_info_i;
  logic [31:0] regM_i_mem_addr;
  logic [31:0] regM_i_valB;
  logic [31:0] regM_i_valE;
  logic [31:0] memory_o_valM;
  logic        memory_o_valid;
  logic        memory_o_misaligned;
  logic        memory_o_stall;

  memory_access_if #(.WIDTH(32)) bus ();

  memory_access #(.WIDTH(32)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .regM_i_valid           (regM_i_valid),
    .regM_load_store_info_i (regM_load_store_info_i),
    .regM_i_mem_addr        (regM_i_mem_addr),
    .regM_i_valB            (regM_i_valB),
    .regM_i_valE            (regM_i_valE),
    .bus                    (bus),
    .memory_o_valM          (memory_o_valM),
    .memory_o_valid         (memory_o_valid),
    .memory_o_misaligned    (memory_o_misaligned),
    .memory_o_stall         (memory_o_stall)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] LB  = 8'h01;
  localparam logic [7:0] LH  = 8'h02;
  localparam logic [7:0] LW  = 8'h04;
  localparam logic [7:0] LBU = 8'h08;
  localparam logic [7:0] LHU = 8'h10;
  localparam logic [7:0] SB  = 8'h20;
  localparam logic [7:0] SH  = 8'h40;
  localparam logic [7:0] SW  = 8'h80;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] valb;
    logic [31:0] vale;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_valm;
    logic        exp_mis;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    regM_i_valid           = 1'b0;
    regM_load_store_info_i = 8'h00;
    regM_i_mem_addr        = '0;
    regM_i_valB            = '0;
    regM_i_valE            = '0;
    bus.mem_i_ready        = 1'b0;
    bus.mem_i_rvalid       = 1'b0;
    bus.mem_i_rdata        = '0;
  endtask

  task automatic drive(input logic [7:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] e);
    regM_i_valid           = 1'b1;
    regM_load_store_info_i = op;
    regM_i_mem_addr        = a;
    regM_i_valB            = b;
    regM_i_valE            = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // zero-wait bus: ready on first req cycle, rvalid next
  task automatic run_vec(input int idx, input vec_t v);
    bit got = 0;
    bit saw_req = 0;
    bit acc = 0;
    string nm;
    nm = $sformatf("v%0d", idx);
    drive(v.op, v.addr, v.valb, v.vale);
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      regM_i_valid     = 1'b0;
      bus.mem_i_ready  = 1'b0;
      bus.mem_i_rvalid = 1'b0;
      if (acc) begin
        bus.mem_i_rvalid = 1'b1;
        bus.mem_i_rdata  = v.rdata;
        acc = 0;
      end
      if (bus.mem_o_req && !saw_req) begin
        saw_req = 1;
        chk({nm, "_addr"}, bus.mem_o_addr, v.exp_addr);
        chk({nm, "_we"}, 32'(bus.mem_o_we),
            32'(v.exp_we));
        if (v.exp_we) begin
          chk({nm, "_wdata"}, bus.mem_o_wdata,
              v.exp_wdata);
          chk({nm, "_wstrb"}, 32'(bus.mem_o_wstrb),
              32'(v.exp_wstrb));
        end
        bus.mem_i_ready = 1'b1;
        acc = !v.exp_we;
      end
      if (memory_o_valid) begin
        got = 1;
        chk({nm, "_valM"}, memory_o_valM, v.exp_valm);
        chk({nm, "_mis"}, 32'(memory_o_misaligned),
            32'(v.exp_mis));
        chk({nm, "_req"}, 32'(saw_req),
            32'(v.exp_req));
      end
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    idle_inputs();
    tick();
    chk({nm, "_single"}, 32'(memory_o_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] stored;
    bit          seen;

    vt[0]  = '{8'h00, 32'h0, 32'h0, 32'h55, 32'h0,
               0, 0, 32'h0, 32'h0, 4'h0, 32'h55, 0};
    vt[1]  = '{LB, 32'h2001, 32'h0, 32'h0, 32'h123480FF,
               1, 0, 32'h2000, 32'h0, 4'h0,
               32'hFFFFFF80, 0};
    vt[2]  = '{LBU, 32'h2001, 32'h0, 32'h0, 32'h123480FF,
               1, 0, 32'h2000, 32'h0, 4'h0,
               32'h00000080, 0};
    vt[3]  = '{LH, 32'h2002, 32'h0, 32'h0, 32'h80017FFF,
               1, 0, 32'h2000, 32'h0, 4'h0,
               32'hFFFF8001, 0};
    vt[4]  = '{LHU, 32'h2002, 32'h0, 32'h0, 32'h80017FFF,
               1, 0, 32'h2000, 32'h0, 4'h0,
               32'h00008001, 0};
    vt[5]  = '{LW, 32'h2000, 32'h0, 32'h0, 32'h80017FFF,
               1, 0, 32'h2000, 32'h0, 4'h0,
               32'h80017FFF, 0};
    vt[6]  = '{LB, 32'h2003, 32'h0, 32'h0, 32'h7F0000FF,
               1, 0, 32'h2000, 32'h0, 4'h0,
               32'h0000007F, 0};
    vt[7]  = '{SW, 32'h4004, 32'hDEADBEEF, 32'h0, 32'h0,
               1, 1, 32'h4004, 32'hDEADBEEF, 4'hF,
               32'h0, 0};
    vt[8]  = '{SH, 32'h4006, 32'h1234ABCD, 32'h0, 32'h0,
               1, 1, 32'h4004, 32'hABCDABCD, 4'hC,
               32'h0, 0};
    vt[9]  = '{SB, 32'h4001, 32'h00000077, 32'h0, 32'h0,
               1, 1, 32'h4000, 32'h77777777, 4'h2,
               32'h0, 0};
    vt[10] = '{LW, 32'h3002, 32'h0, 32'h0, 32'h0,
               0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
    vt[11] = '{8'h03, 32'h2000, 32'h0, 32'h0, 32'h0,
               0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
    vt[12] = '{LH, 32'h2001, 32'h0, 32'h0, 32'h0,
               0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
    vt[13] = '{SH, 32'h2003, 32'h0, 32'h0, 32'h0,
               0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
    vt[14] = '{SW, 32'h2001, 32'h0, 32'h0, 32'h0,
               0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_req", 32'(bus.mem_o_req), 32'd0);
    chk("rst_valid", 32'(memory_o_valid), 32'd0);
    chk("rst_valM", memory_o_valM, 32'd0);
    chk("rst_stall", 32'(memory_o_stall), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

    // SB with two bus wait cycles
    drive(SB, 32'h1003, 32'h000000A5, 32'h0);
    #1 chk("sb_stall_c0", 32'(memory_o_stall), 32'd1);
    tick();
    regM_i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("sb_req", 32'(bus.mem_o_req), 32'd1);
      chk("sb_addr", bus.mem_o_addr, 32'h1000);
      chk("sb_wdata", bus.mem_o_wdata, 32'hA5A5A5A5);
      chk("sb_wstrb", 32'(bus.mem_o_wstrb), 32'h8);
      bus.mem_i_ready = (k == 2);
      #1 chk("sb_stall", 32'(memory_o_stall),
             32'(k != 2));
      chk("sb_early", 32'(memory_o_valid), 32'd0);
      tick();
    end
    bus.mem_i_ready = 1'b0;
    chk("sb_valid", 32'(memory_o_valid), 32'd1);
    chk("sb_valM", memory_o_valM, 32'd0);
    chk("sb_req_off", 32'(bus.mem_o_req), 32'd0);
    tick();

    // reset while a request is outstanding
    drive(SW, 32'h5000, 32'h1, 32'h0);
    tick();
    regM_i_valid = 1'b0;
    chk("rq_req_pre", 32'(bus.mem_o_req), 32'd1);
    rst_n = 1'b0;
    #1 chk("rq_req_rst", 32'(bus.mem_o_req), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset mid-load in RESP
    drive(LW, 32'h2000, 32'h0, 32'h0);
    tick();
    regM_i_valid = 1'b0;
    bus.mem_i_ready = 1'b1;
    tick();
    bus.mem_i_ready = 1'b0;
    chk("rl_stall_resp", 32'(memory_o_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rl_req", 32'(bus.mem_o_req), 32'd0);
    chk("rl_valid", 32'(memory_o_valid), 32'd0);
    chk("rl_stall", 32'(memory_o_stall), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.mem_i_rvalid = 1'b1;
    bus.mem_i_rdata  = 32'hFFFFFFFF;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.mem_i_rvalid = 1'b0;
      if (memory_o_valid) seen = 1;
    end
    chk("rl_no_valid", 32'(seen), 32'd0);

    // back-to-back ADD, SW, LW
    stored = 32'h0;
    drive(8'h00, 32'h0, 32'h0, 32'h55);       // c0
    #1 chk("bb_stall_c0", 32'(memory_o_stall), 32'd0);
    tick();                                   // c1
    chk("bb_valid_c1", 32'(memory_o_valid), 32'd1);
    chk("bb_valM_c1", memory_o_valM, 32'h55);
    drive(SW, 32'h4000, 32'hCAFEF00D, 32'h0);
    #1 chk("bb_stall_c1", 32'(memory_o_stall), 32'd1);
    tick();                                   // c2
    chk("bb_req_c2", 32'(bus.mem_o_req), 32'd1);
    chk("bb_valid_c2", 32'(memory_o_valid), 32'd0);
    stored = bus.mem_o_wdata;
    bus.mem_i_ready = 1'b1;
    #1 chk("bb_stall_c2", 32'(memory_o_stall), 32'd0);
    tick();                                   // c3
    bus.mem_i_ready = 1'b0;
    chk("bb_valid_c3", 32'(memory_o_valid), 32'd1);
    chk("bb_valM_c3", memory_o_valM, 32'h0);
    drive(LW, 32'h4000, 32'h0, 32'h0);
    #1 chk("bb_stall_c3", 32'(memory_o_stall), 32'd1);
    tick();                                   // c4
    chk("bb_req_c4", 32'(bus.mem_o_req), 32'd1);
    chk("bb_valid_c4", 32'(memory_o_valid), 32'd0);
    bus.mem_i_ready = 1'b1;
    #1 chk("bb_stall_c4", 32'(memory_o_stall), 32'd1);
    tick();                                   // c5
    bus.mem_i_ready  = 1'b0;
    bus.mem_i_rvalid = 1'b1;
    bus.mem_i_rdata  = stored;
    chk("bb_valid_c5", 32'(memory_o_valid), 32'd0);
    #1 chk("bb_stall_c5", 32'(memory_o_stall), 32'd0);
    tick();                                   // c6
    idle_inputs();
    chk("bb_valid_c6", 32'(memory_o_valid), 32'd1);
    chk("bb_valM_c6", memory_o_valM, 32'hCAFEF00D);
    tick();
    chk("bb_valid_c7", 32'(memory_o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
